// File: rtl/panda_div_ctrl.sv
// Restoring-division sequencer for DIV/DIVU/REM/REMU. It computes one quotient bit per cycle
// and performs all arithmetic through an external (Width+1)-bit add/subtract unit.
module panda_div_ctrl #(
    parameter int Width = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [Width-1:0]   operand_a_i,
    input  logic [Width-1:0]   operand_b_i,
    input  logic               signed_i,
    input  logic               rem_i,
    input  logic               kill_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [Width-1:0]   result_o,
    output logic [Width:0]     adder_operand_a_o,
    output logic [Width:0]     adder_operand_b_o,
    output logic               adder_subtract_o,
    input  logic [Width:0]     adder_result_i
);

    localparam int CntW = (Width > 1) ? $clog2(Width) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ABS_A,
        ABS_B,
        DIV,
        FIX,
        DONE
    } state_t;

    state_t             state_reg;
    state_t             state_next;

    // q_reg holds the raw dividend first, then |A|, then it becomes the quotient
    // as the quotient bits are shifted in.
    logic [Width-1:0]   q_reg;
    logic [Width-1:0]   b_reg;
    logic [Width-1:0]   rem_reg;
    logic [Width-1:0]   result_reg;
    logic [CntW-1:0]    cnt_reg;
    logic               a_neg_reg;
    logic               b_neg_reg;
    logic               rem_sel_reg;

    logic               accept;
    logic               b_zero;
    logic               trial_neg;

    assign accept    = (state_reg == IDLE) && valid_i && !kill_i;
    assign b_zero    = (operand_b_i == '0);
    assign trial_neg = adder_result_i[Width];
    assign result_o  = result_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        ready_o           = 1'b0;
        valid_o           = 1'b0;
        adder_operand_a_o = '0;
        adder_operand_b_o = '0;
        adder_subtract_o  = 1'b0;
        case (state_reg)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i && !kill_i) begin
                    state_next = b_zero ? DONE : ABS_A;
                end
            end
            ABS_A: begin
                adder_operand_b_o = {1'b0, q_reg};
                adder_subtract_o  = a_neg_reg;
                state_next        = ABS_B;
            end
            ABS_B: begin
                adder_operand_b_o = {1'b0, b_reg};
                adder_subtract_o  = b_neg_reg;
                state_next        = DIV;
            end
            DIV: begin
                // Trial subtraction of |B| from the partial remainder shifted by one.
                adder_operand_a_o = {rem_reg, q_reg[Width-1]};
                adder_operand_b_o = {1'b0, b_reg};
                adder_subtract_o  = 1'b1;
                if (cnt_reg == '0) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                adder_operand_b_o = {1'b0, (rem_sel_reg ? rem_reg : q_reg)};
                adder_subtract_o  = rem_sel_reg ? a_neg_reg : (a_neg_reg ^ b_neg_reg);
                state_next        = DONE;
            end
            DONE: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (kill_i) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_reg       <= '0;
            b_reg       <= '0;
            rem_reg     <= '0;
            result_reg  <= '0;
            cnt_reg     <= '0;
            a_neg_reg   <= 1'b0;
            b_neg_reg   <= 1'b0;
            rem_sel_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        q_reg       <= operand_a_i;
                        b_reg       <= operand_b_i;
                        rem_reg     <= '0;
                        a_neg_reg   <= signed_i & operand_a_i[Width-1];
                        b_neg_reg   <= signed_i & operand_b_i[Width-1];
                        rem_sel_reg <= rem_i;
                        // A zero divisor skips the datapath; the answer is known now.
                        if (b_zero) begin
                            result_reg <= rem_i ? operand_a_i : '1;
                        end
                    end
                end
                ABS_A: begin
                    q_reg <= adder_result_i[Width-1:0];
                end
                ABS_B: begin
                    b_reg   <= adder_result_i[Width-1:0];
                    cnt_reg <= CntW'(Width - 1);
                end
                DIV: begin
                    if (!trial_neg) begin
                        rem_reg <= adder_result_i[Width-1:0];
                        q_reg   <= {q_reg[Width-2:0], 1'b1};
                    end else begin
                        rem_reg <= {rem_reg[Width-2:0], q_reg[Width-1]};
                        q_reg   <= {q_reg[Width-2:0], 1'b0};
                    end
                    cnt_reg <= cnt_reg - 1'b1;
                end
                FIX: begin
                    result_reg <= adder_result_i[Width-1:0];
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_panda_div_ctrl.sv
// Bench for panda_div_ctrl. It models the external adder, drives directed requests
// and uses a scoreboard to check the result value and the cycle on which it arrives.
module tb_panda_div_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic        signed_i;
    logic        rem_i;
    logic        kill_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic [32:0] adder_operand_a_o;
    logic [32:0] adder_operand_b_o;
    logic        adder_subtract_o;
    logic [32:0] adder_result_i;

    panda_div_ctrl #(.Width(32)) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .valid_i           (valid_i),
        .ready_o           (ready_o),
        .operand_a_i       (operand_a_i),
        .operand_b_i       (operand_b_i),
        .signed_i          (signed_i),
        .rem_i             (rem_i),
        .kill_i            (kill_i),
        .valid_o           (valid_o),
        .ready_i           (ready_i),
        .result_o          (result_o),
        .adder_operand_a_o (adder_operand_a_o),
        .adder_operand_b_o (adder_operand_b_o),
        .adder_subtract_o  (adder_subtract_o),
        .adder_result_i    (adder_result_i)
    );

    // External 33-bit adder model
    assign adder_result_i = adder_subtract_o ? (adder_operand_a_o - adder_operand_b_o)
                                             : (adder_operand_a_o + adder_operand_b_o);

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic        r;
        logic [31:0] res;
        int          lat;
    } vec_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops an expectation when a result appears and checks it is held until taken.
    exp_t cur;
    logic active = 1'b0;
    logic bogus  = 1'b0;
    always @(negedge clk_i) begin
        if (rst_ni && valid_o) begin
            if (!active && !bogus) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: actual result=%0h required no valid_o", result_o);
                    bogus = 1'b1;
                end else begin
                    cur    = sb.pop_front();
                    active = 1'b1;
                    chk("result", result_o, cur.res);
                    chk("latency_cycle", cyc, cur.cyc);
                    $display("txn: result=%08h expected=%08h at cycle %0d", result_o, cur.res, cyc);
                end
            end else if (active) begin
                chk("hold_result", result_o, cur.res);
                chk("hold_ready_o", ready_o, 1'b0);
            end
            if (ready_i) begin
                active = 1'b0;
                bogus  = 1'b0;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!ready_o && n < 200) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        if (!ready_o) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: actual ready_o=0 required 1 within 200 cycles");
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic r, input logic push, input logic [31:0] res,
                         input int lat, output int t);
        wait_idle();
        operand_a_i = a;
        operand_b_i = b;
        signed_i    = s;
        rem_i       = r;
        valid_i     = 1'b1;
        t           = cyc;
        if (push) sb.push_back('{res, cyc + lat});
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
    endtask

    vec_t vecs[14];

    initial begin
        int t;
        int n;
        vecs[0]  = '{32'd100,        32'd7,          1'b0, 1'b0, 32'd14,         36};
        vecs[1]  = '{32'd100,        32'd7,          1'b0, 1'b1, 32'd2,          36};
        vecs[2]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 1'b0, 32'hFFFF_FFFD,  36};
        vecs[3]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 1'b1, 32'hFFFF_FFFF,  36};
        vecs[4]  = '{32'd5,          32'd0,          1'b0, 1'b0, 32'hFFFF_FFFF,  1};
        vecs[5]  = '{32'd5,          32'd0,          1'b0, 1'b1, 32'd5,          1};
        vecs[6]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b0, 32'h8000_0000,  36};
        vecs[7]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b1, 32'd0,          36};
        vecs[8]  = '{32'd7,          32'hFFFF_FFFE,  1'b1, 1'b0, 32'hFFFF_FFFD,  36};
        vecs[9]  = '{32'd7,          32'hFFFF_FFFE,  1'b1, 1'b1, 32'd1,          36};
        vecs[10] = '{32'hFFFF_FFF9,  32'd2,          1'b0, 1'b0, 32'h7FFF_FFFC,  36};
        vecs[11] = '{32'hFFFF_FFF9,  32'd0,          1'b1, 1'b1, 32'hFFFF_FFF9,  1};
        vecs[12] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 1'b0, 32'hFFFF_FFFF,  36};
        vecs[13] = '{32'h1234_5678,  32'h0000_1000,  1'b0, 1'b1, 32'h0000_0678,  36};

        rst_ni      = 1'b0;
        valid_i     = 1'b0;
        operand_a_i = '0;
        operand_b_i = '0;
        signed_i    = 1'b0;
        rem_i       = 1'b0;
        kill_i      = 1'b0;
        ready_i     = 1'b1;

        #12;
        chk("reset_ready_o", ready_o, 1'b1);
        chk("reset_valid_o", valid_o, 1'b0);
        chk("reset_result_o", result_o, 32'd0);
        chk("reset_adder_a", adder_operand_a_o, 33'd0);
        chk("reset_adder_b", adder_operand_b_o, 33'd0);
        chk("reset_adder_sub", adder_subtract_o, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].r, 1'b1, vecs[i].res, vecs[i].lat, t);
        end

        // Consumer stalls for three cycles while the result is presented.
        wait_idle();
        ready_i = 1'b0;
        issue(32'd100, 32'd7, 1'b0, 1'b0, 1'b1, 32'd14, 36, t);
        n = 0;
        while (!valid_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        chk("stall_valid_seen", valid_o, 1'b1);
        repeat (2) @(negedge clk_i);
        @(posedge clk_i);
        #1;
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("post_handshake_ready_o", ready_o, 1'b1);
        chk("post_handshake_valid_o", valid_o, 1'b0);

        // Abort during division iteration 10, then a fresh request.
        issue(32'd100, 32'd7, 1'b0, 1'b0, 1'b0, 32'd0, 0, t);
        while (cyc < t + 13) begin
            @(posedge clk_i);
            #1;
        end
        kill_i = 1'b1;
        @(posedge clk_i);
        #1;
        kill_i = 1'b0;
        chk("kill_ready_o", ready_o, 1'b1);
        chk("kill_valid_o", valid_o, 1'b0);
        repeat (40) @(posedge clk_i);
        #1;
        issue(32'd100, 32'd7, 1'b0, 1'b0, 1'b1, 32'd14, 36, t);

        // kill_i together with valid_i in IDLE must not start a request.
        wait_idle();
        operand_a_i = 32'd100;
        operand_b_i = 32'd7;
        valid_i     = 1'b1;
        kill_i      = 1'b1;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        kill_i  = 1'b0;
        chk("kill_in_idle_ready_o", ready_o, 1'b1);
        repeat (40) @(posedge clk_i);
        #1;

        // Asynchronous reset while dividing.
        issue(32'd100, 32'd7, 1'b0, 1'b0, 1'b0, 32'd0, 0, t);
        repeat (5) @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        chk("async_rst_ready_o", ready_o, 1'b1);
        chk("async_rst_valid_o", valid_o, 1'b0);
        chk("async_rst_result_o", result_o, 32'd0);
        chk("async_rst_adder_b", adder_operand_b_o, 33'd0);
        chk("async_rst_adder_sub", adder_subtract_o, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        issue(32'd100, 32'd7, 1'b0, 1'b1, 1'b1, 32'd2, 36, t);

        n = 0;
        while ((sb.size() != 0 || active) && n < 200) begin
            @(posedge clk_i);
            n++;
        end
        if (sb.size() != 0 || active) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: actual pending=%0d required 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
